// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Holds operands/strobe for ALU_LAT cycles, then returns the result to the winner.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_z,
  output logic        rsp0_n,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_z,
  output logic        rsp1_n,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_add,
  output logic        alu_inc,
  output logic        alu_neg,
  output logic        alu_sub,
  input  logic [31:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

  state_t      state;
  state_t      state_nx;
  logic        last_grant;
  logic        owner;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        z_q;
  logic        n_q;
  logic [3:0]  cnt;
  logic        pick1;
  logic        idle;
  logic        accept;
  logic        cnt_done;
  logic        rsp_fire;

  // Port 1 wins only when alone or when port 0 was served last.
  assign pick1 = req1_valid & (~req0_valid | ~last_grant);
  assign idle  = rst_n & (state == IDLE);

  assign req0_ready = idle & req0_valid & ~pick1;
  assign req1_ready = idle & pick1;
  assign accept     = req0_ready | req1_ready;

  assign cnt_done = (state == EXEC) & (cnt == CNT_LAST);
  assign rsp_fire = (state == RESP) &
                    (owner ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: if (cnt_done) state_nx = RESP;
      RESP: if (rsp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt        <= '0;
        last_grant <= pick1;
        owner      <= pick1;
        op_q       <= pick1 ? req1_op : req0_op;
        a_q        <= pick1 ? req1_a : req0_a;
        b_q        <= pick1 ? req1_b : req0_b;
      end else if ((state == EXEC) && !cnt_done) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else if (cnt_done) begin
      res_q <= alu_out;
      z_q   <= alu_z;
      n_q   <= alu_n;
    end
  end

  assign alu_a = a_q;
  assign alu_b = b_q;

  always_comb begin
    alu_add = 1'b0;
    alu_sub = 1'b0;
    alu_inc = 1'b0;
    alu_neg = 1'b0;
    if (state == EXEC) begin
      unique case (op_q)
        2'b00: alu_add = 1'b1;
        2'b01: alu_sub = 1'b1;
        2'b10: alu_inc = 1'b1;
        2'b11: alu_neg = 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp0_valid  = (state == RESP) & ~owner;
  assign rsp1_valid  = (state == RESP) & owner;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_z      = z_q;
  assign rsp1_z      = z_q;
  assign rsp0_n      = n_q;
  assign rsp1_n      = n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner sequences,
// and randomized traffic against a queue-based reference.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT with ALU_LAT=1
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_z, rsp0_n, rsp1_z, rsp1_n;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_add, alu_inc, alu_neg, alu_sub, alu_z, alu_n;

  // DUT with ALU_LAT=4
  logic        rst4_n;
  logic        d4_req0_valid, d4_req0_ready, d4_req1_valid, d4_req1_ready;
  logic [1:0]  d4_req0_op, d4_req1_op;
  logic [31:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
  logic        d4_rsp0_valid, d4_rsp0_ready, d4_rsp1_valid, d4_rsp1_ready;
  logic [31:0] d4_rsp0_result, d4_rsp1_result;
  logic        d4_rsp0_z, d4_rsp0_n, d4_rsp1_z, d4_rsp1_n;
  logic [31:0] d4_alu_a, d4_alu_b, d4_alu_out;
  logic        d4_alu_add, d4_alu_inc, d4_alu_neg, d4_alu_sub;
  logic        d4_alu_z, d4_alu_n;

  alu_arbiter #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_z(rsp0_z), .rsp0_n(rsp0_n),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_z(rsp1_z), .rsp1_n(rsp1_n),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_add(alu_add), .alu_inc(alu_inc),
    .alu_neg(alu_neg), .alu_sub(alu_sub),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n)
  );

  alu_arbiter #(.ALU_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n),
    .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready),
    .req0_op(d4_req0_op), .req0_a(d4_req0_a), .req0_b(d4_req0_b),
    .req1_valid(d4_req1_valid), .req1_ready(d4_req1_ready),
    .req1_op(d4_req1_op), .req1_a(d4_req1_a), .req1_b(d4_req1_b),
    .rsp0_valid(d4_rsp0_valid), .rsp0_ready(d4_rsp0_ready),
    .rsp0_result(d4_rsp0_result), .rsp0_z(d4_rsp0_z),
    .rsp0_n(d4_rsp0_n),
    .rsp1_valid(d4_rsp1_valid), .rsp1_ready(d4_rsp1_ready),
    .rsp1_result(d4_rsp1_result), .rsp1_z(d4_rsp1_z),
    .rsp1_n(d4_rsp1_n),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b),
    .alu_add(d4_alu_add), .alu_inc(d4_alu_inc),
    .alu_neg(d4_alu_neg), .alu_sub(d4_alu_sub),
    .alu_out(d4_alu_out), .alu_z(d4_alu_z), .alu_n(d4_alu_n)
  );

  // Behavioural ALU for the ALU_LAT=1 instance
  always_comb begin
    alu_out = '0;
    if (alu_add)      alu_out = alu_a + alu_b;
    else if (alu_sub) alu_out = alu_a - alu_b;
    else if (alu_inc) alu_out = alu_a + 32'd1;
    else if (alu_neg) alu_out = 32'd0 - alu_a;
  end
  assign alu_z = (alu_out == 32'd0);
  assign alu_n = alu_out[31];

  // Slow ALU: garbage until the 4th strobed cycle
  int d4_k;
  logic d4_any;
  assign d4_any = d4_alu_add | d4_alu_sub | d4_alu_inc | d4_alu_neg;
  always_ff @(posedge clk) d4_k <= d4_any ? d4_k + 1 : 0;
  always_comb begin
    d4_alu_out = '0;
    if (d4_alu_sub)
      d4_alu_out = (d4_k == 3) ? d4_alu_a - d4_alu_b
                               : 32'hBAD0_0000 | 32'(d4_k);
  end
  assign d4_alu_z = (d4_alu_out == 32'd0);
  assign d4_alu_n = d4_alu_out[31];

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] ref_alu(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a + 32'd1;
      default: r = 32'd0 - a;
    endcase
    return {r == 32'd0, r[31], r};
  endfunction

  function automatic logic rdy(input int p);
    return (p == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic rsp_v(input int p);
    return (p == 1) ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [33:0] rsp_d(input int p);
    return (p == 1) ? {rsp1_z, rsp1_n, rsp1_result}
                    : {rsp0_z, rsp0_n, rsp0_result};
  endfunction

  task automatic drive(input int p, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic reset1();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One request on the ALU_LAT=1 instance, response taken immediately
  task automatic run_op(input int p, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [33:0] rzn, output int w,
                        output int lat, output int good,
                        output int other);
    drive(p, 1'b1, op, a, b);
    w = 0;
    @(negedge clk);
    while (!rdy(p) && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 drive(p, 1'b0, op, a, b);
    lat = 0; good = 0; other = 0;
    do begin
      @(negedge clk);
      lat++;
      if ({alu_neg, alu_inc, alu_sub, alu_add} == (4'b0001 << op) &&
          alu_a == a && alu_b == b)
        good++;
      if (rsp_v(1 - p)) other++;
    end while (!rsp_v(p) && lat < 20);
    rzn = rsp_d(p);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          p;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
  } vec_t;

  vec_t        tbl[6];
  logic [33:0] q0[$];
  logic [33:0] q1[$];

  task automatic rsp_check();
    if (rsp0_valid && rsp0_ready) begin
      chk("rnd_q0_nonempty", q0.size() != 0, 1);
      if (q0.size() != 0) chk("rnd_rsp0", rsp_d(0), q0.pop_front());
    end
    if (rsp1_valid && rsp1_ready) begin
      chk("rnd_q1_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) chk("rnd_rsp1", rsp_d(1), q1.pop_front());
    end
    chk("rnd_rsp_excl", rsp0_valid & rsp1_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] rzn;
    logic [33:0] held;
    int          w, lat, good, other, gp, last, eg, st;
    logic        acc0, acc1;

    rst_n = 1'b0; rst4_n = 1'b0;
    drive(0, 1'b1, 2'd0, 32'd1, 32'd1);
    drive(1, 1'b0, 2'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    {d4_req0_valid, d4_req0_op, d4_req0_a, d4_req0_b} = '0;
    {d4_req1_valid, d4_req1_op, d4_req1_a, d4_req1_b} = '0;
    d4_rsp0_ready = 1'b1; d4_rsp1_ready = 1'b1;

    // Reset state, with a request pending
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_alu_ab", {alu_a, alu_b} == 64'd0, 1);
    chk("rst_strobes", {alu_add, alu_sub, alu_inc, alu_neg}, 0);
    chk("rst_result", {rsp0_z, rsp0_n, rsp0_result}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; rst4_n = 1'b1;
    drive(0, 1'b0, 2'd0, 32'd0, 32'd0);

    // Vector table: one op at a time
    tbl[0] = '{0, 2'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    tbl[1] = '{1, 2'd1, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0};
    tbl[2] = '{0, 2'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0};
    tbl[3] = '{1, 2'd3, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    tbl[4] = '{1, 2'd3, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0};
    tbl[5] = '{0, 2'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].p, tbl[i].op, tbl[i].a, tbl[i].b,
             rzn, w, lat, good, other);
      chk($sformatf("vec%0d_ready_wait", i), w, 0);
      chk($sformatf("vec%0d_strobe_cycles", i), good, 1);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_other_rsp", i), other, 0);
      chk($sformatf("vec%0d_rzn", i), rzn,
          {tbl[i].z, tbl[i].n, tbl[i].res});
    end

    // Tie after reset: grants alternate 0,1,0,1
    reset1();
    drive(0, 1'b1, 2'd0, 32'd1, 32'd2);
    drive(1, 1'b1, 2'd0, 32'd10, 32'd20);
    for (int i = 0; i < 4; i++) begin
      w = 0;
      @(negedge clk);
      while (!(req0_ready | req1_ready) && w < 20) begin
        @(negedge clk);
        w++;
      end
      gp = req1_ready ? 1 : 0;
      chk($sformatf("tie%0d_ready_found", i), w < 20, 1);
      chk($sformatf("tie%0d_one_ready", i), req0_ready & req1_ready, 0);
      chk($sformatf("tie%0d_grant", i), gp, i % 2);
      w = 0;
      @(negedge clk);
      while (!(rsp0_valid | rsp1_valid) && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("tie%0d_rsp_port", i), {rsp1_valid, rsp0_valid},
          (gp == 1) ? 2 : 1);
      chk($sformatf("tie%0d_result", i), rsp_d(gp),
          (gp == 1) ? 34'd30 : 34'd3);
    end
    @(posedge clk);
    #1 drive(0, 1'b0, 2'd0, 0, 0);
    drive(1, 1'b0, 2'd0, 0, 0);

    // Response backpressure on port 1
    rsp1_ready = 1'b0;
    run_op(1, 2'd0, 32'd100, 32'd23, held, w, lat, good, other);
    chk("bp_first_rsp", held, 34'd123);
    drive(0, 1'b1, 2'd0, 32'd4, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), rsp1_valid, 1);
      chk($sformatf("bp%0d_data", i), rsp_d(1), held);
      chk($sformatf("bp%0d_req0_ready", i), req0_ready, 0);
      @(posedge clk);
      #1;
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_no_accept", req0_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next_accept", req0_ready, 1);
    @(posedge clk);
    #1 drive(0, 1'b0, 2'd0, 0, 0);
    w = 0;
    @(negedge clk);
    while (!rsp0_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_port0_rsp", rsp_d(0), 34'd8);
    @(posedge clk);
    #1;

    // Randomized traffic against queue reference
    reset1();
    last = 1; acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0)
        drive(0, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
              $urandom, $urandom);
      if (!req1_valid || acc1)
        drive(1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
              $urandom, $urandom);
      rsp0_ready = ($urandom_range(3, 0) != 0);
      rsp1_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      chk("rnd_ready_excl", req0_ready & req1_ready, 0);
      if (acc0 | acc1) begin
        if (req0_valid && req1_valid) eg = (last == 1) ? 0 : 1;
        else eg = req1_valid ? 1 : 0;
        chk("rnd_grant", acc1 ? 1 : 0, eg);
        chk("rnd_no_acc_with_rsp", rsp0_valid | rsp1_valid, 0);
        if (acc0) q0.push_back(ref_alu(req0_op, req0_a, req0_b));
        if (acc1) q1.push_back(ref_alu(req1_op, req1_a, req1_b));
        last = acc1 ? 1 : 0;
      end
      rsp_check();
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 2'd0, 0, 0);
    drive(1, 1'b0, 2'd0, 0, 0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rsp_check();
      @(posedge clk);
      #1;
    end
    chk("rnd_drained", q0.size() + q1.size(), 0);

    // ALU_LAT=4 SUB: capture only the 4th EXEC cycle
    d4_req0_valid = 1'b1; d4_req0_op = 2'd1;
    d4_req0_a = 32'd100; d4_req0_b = 32'd30;
    @(negedge clk);
    chk("l4_ready", d4_req0_ready, 1);
    @(posedge clk);
    #1 d4_req0_valid = 1'b0;
    lat = 0; good = 0; other = 0;
    do begin
      @(negedge clk);
      lat++;
      if ({d4_alu_neg, d4_alu_inc, d4_alu_sub, d4_alu_add} == 4'b0010)
        good++;
      if (d4_rsp1_valid) other++;
    end while (!d4_rsp0_valid && lat < 20);
    chk("l4_sub_cycles", good, 4);
    chk("l4_latency", lat, 5);
    chk("l4_other_rsp", other, 0);
    chk("l4_result", {d4_rsp0_z, d4_rsp0_n, d4_rsp0_result}, 34'd70);
    @(posedge clk);
    #1;

    // Reset in the 2nd EXEC cycle discards the op
    d4_req0_valid = 1'b1; d4_req0_a = 32'd9; d4_req0_b = 32'd4;
    @(negedge clk);
    chk("mr_accept", d4_req0_ready, 1);
    @(posedge clk);
    #1 d4_req0_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mr_exec2_sub", d4_alu_sub, 1);
    rst4_n = 1'b0;
    #1;
    chk("mr_strobes", {d4_alu_add, d4_alu_sub, d4_alu_inc, d4_alu_neg}, 0);
    chk("mr_alu_ab", {d4_alu_a, d4_alu_b} == 64'd0, 1);
    d4_req0_valid = 1'b1; d4_req1_valid = 1'b1;
    d4_req0_op = 2'd0; d4_req1_op = 2'd0;
    #1;
    chk("mr_ready_in_rst", {d4_req0_ready, d4_req1_ready}, 0);
    st = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d4_rsp0_valid | d4_rsp1_valid) st++;
    end
    @(posedge clk);
    #1 rst4_n = 1'b1;
    @(negedge clk);
    if (d4_rsp0_valid | d4_rsp1_valid) st++;
    chk("mr_no_rsp", st, 0);
    chk("mr_tie_grant", {d4_req1_ready, d4_req0_ready}, 2'b01);
    @(posedge clk);
    #1 d4_req0_valid = 1'b0; d4_req1_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
